// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage.
// Owns the 15-entry register file and the processor status FSM, derives
// source/destination register IDs from the fetched fields and presents
// registered operands to execute one cycle later.
// Optional build macro: DECODE_BYPASS_EN. When it is defined, writeback data
// arriving in the same cycle is forwarded into valA/valB. When it is not
// defined, reads see the register contents from before that cycle's write.
//
//   state  | meaning
//   RUN    | decoding instructions, stat = AOK
//   HALT   | halt fetched, decode frozen, writebacks still drain
//   FAULT  | address or illegal-instruction fault, decode frozen
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd2048,
  parameter logic [3:0]  RNONE      = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        instr_validity,
  input  logic        imem_error,
  input  logic        hlt,
  input  logic [3:0]  wb_dstE,
  input  logic [63:0] wb_valE,
  input  logic [3:0]  wb_dstM,
  input  logic [63:0] wb_valM,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic [3:0]  out_ifun,
  output logic [63:0] out_valC,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [1:0]  stat
);

  localparam logic [3:0] RSP = 4'h4;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  stat_q, stat_d;
  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_icode_q, out_icode_d;
  logic [3:0]  out_ifun_q, out_ifun_d;
  logic [63:0] out_valc_q, out_valc_d;
  logic [3:0]  src_a_q, src_a_d;
  logic [3:0]  src_b_q, src_b_d;
  logic [3:0]  dst_e_q, dst_e_d;
  logic [3:0]  dst_m_q, dst_m_d;
  logic [63:0] val_a_q, val_a_d;
  logic [63:0] val_b_q, val_b_d;

  logic [3:0]  id_src_a, id_src_b, id_dst_e, id_dst_m;
  logic [63:0] rd_a, rd_b;

  // Register ID derivation from the raw fetch fields.
  always_comb begin
    id_src_a = RNONE;
    id_src_b = RNONE;
    id_dst_e = RNONE;
    id_dst_m = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: id_src_a = rA;
      4'h9, 4'hB:             id_src_a = RSP;
      default:                id_src_a = RNONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       id_src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: id_src_b = RSP;
      default:                id_src_b = RNONE;
    endcase
    // cmovXX writes rB here; the condition squash happens in execute.
    case (icode)
      4'h2, 4'h3, 4'h6:       id_dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: id_dst_e = RSP;
      default:                id_dst_e = RNONE;
    endcase
    case (icode)
      4'h5, 4'hB:             id_dst_m = rA;
      default:                id_dst_m = RNONE;
    endcase
  end

  // Register file read ports, with optional same-cycle forwarding (M over E).
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (id_src_a != RNONE) rd_a = regs_q[id_src_a];
    if (id_src_b != RNONE) rd_b = regs_q[id_src_b];
`ifdef DECODE_BYPASS_EN
    if (id_src_a != RNONE) begin
      if (id_src_a == wb_dstE) rd_a = wb_valE;
      if (id_src_a == wb_dstM) rd_a = wb_valM;
    end
    if (id_src_b != RNONE) begin
      if (id_src_b == wb_dstE) rd_b = wb_valE;
      if (id_src_b == wb_dstM) rd_b = wb_valM;
    end
`else
`endif
  end

  // Next-state: writeback, status FSM and decode output capture.
  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    regs_d      = regs_q;
    out_valid_d = 1'b0;
    out_icode_d = out_icode_q;
    out_ifun_d  = out_ifun_q;
    out_valc_d  = out_valc_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_e_d     = dst_e_q;
    dst_m_d     = dst_m_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;

    // M is applied last so it wins a same-register collision (popq %rsp).
    if (wb_dstE != RNONE) regs_d[wb_dstE] = wb_valE;
    if (wb_dstM != RNONE) regs_d[wb_dstM] = wb_valM;

    if (state_q == ST_RUN && in_valid) begin
      out_valid_d = 1'b1;
      out_icode_d = icode;
      out_ifun_d  = ifun;
      out_valc_d  = valC;
      src_a_d     = RNONE;
      src_b_d     = RNONE;
      dst_e_d     = RNONE;
      dst_m_d     = RNONE;
      val_a_d     = '0;
      val_b_d     = '0;
      if (imem_error) begin
        state_d = ST_FAULT;
        stat_d  = STAT_ADR;
      end else if (!instr_validity) begin
        state_d = ST_FAULT;
        stat_d  = STAT_INS;
      end else if (hlt) begin
        state_d = ST_HALT;
        stat_d  = STAT_HLT;
      end else begin
        stat_d  = STAT_AOK;
        src_a_d = id_src_a;
        src_b_d = id_src_b;
        dst_e_d = id_dst_e;
        dst_m_d = id_dst_m;
        val_a_d = (icode == 4'h7 || icode == 4'h8) ? valP : rd_a;
        val_b_d = rd_b;
      end
    end
  end

  // State registers; reset beats any writeback or decode in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stat_q      <= STAT_AOK;
      for (int i = 0; i < 15; i++) regs_q[i] <= (i == 4) ? STACK_INIT : 64'd0;
      out_valid_q <= 1'b0;
      out_icode_q <= '0;
      out_ifun_q  <= '0;
      out_valc_q  <= '0;
      src_a_q     <= RNONE;
      src_b_q     <= RNONE;
      dst_e_q     <= RNONE;
      dst_m_q     <= RNONE;
      val_a_q     <= '0;
      val_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_ifun_q  <= out_ifun_d;
      out_valc_q  <= out_valc_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_e_q     <= dst_e_d;
      dst_m_q     <= dst_m_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_ifun  = out_ifun_q;
  assign out_valC  = out_valc_q;
  assign srcA      = src_a_q;
  assign srcB      = src_b_q;
  assign dstE      = dst_e_q;
  assign dstM      = dst_m_q;
  assign valA      = val_a_q;
  assign valB      = val_b_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback with hand-computed expected values.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_validity, imem_error, hlt;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [63:0] wb_valE, wb_valM;
  logic        out_valid;
  logic [3:0]  out_icode, out_ifun, srcA, srcB, dstE, dstM;
  logic [63:0] out_valC, valA, valB;
  logic [1:0]  stat;

  int checks   = 0;
  int failures = 0;

  decode_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP),
    .instr_validity(instr_validity), .imem_error(imem_error), .hlt(hlt),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .out_valid(out_valid), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_valC(out_valC), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid       = 1'b0;
    icode          = 4'h1;
    ifun           = 4'h0;
    rA             = 4'hF;
    rB             = 4'hF;
    valC           = 64'd0;
    valP           = 64'd0;
    instr_validity = 1'b1;
    imem_error     = 1'b0;
    hlt            = 1'b0;
    wb_dstE        = 4'hF;
    wb_valE        = 64'd0;
    wb_dstM        = 4'hF;
    wb_valM        = 64'd0;
  endtask

  task automatic decode(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] p);
    in_valid = 1'b1;
    icode    = ic;
    rA       = a;
    rB       = b;
    valP     = p;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_bypass;
    do_reset();

    // Reset values
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_srcA", {60'd0, srcA}, 64'hF);
    check("rst_srcB", {60'd0, srcB}, 64'hF);
    check("rst_dstE", {60'd0, dstE}, 64'hF);
    check("rst_dstM", {60'd0, dstM}, 64'hF);
    check("rst_valA", valA, 64'd0);
    check("rst_valB", valB, 64'd0);
    check("rst_stat", {62'd0, stat}, 64'd0);

    // pushq %rbx
    decode(4'hA, 4'h3, 4'hF, 64'h2);
    valC = 64'h77;
    tick();
    idle();
    check("push_valid", {63'd0, out_valid}, 64'd1);
    check("push_srcA", {60'd0, srcA}, 64'h3);
    check("push_srcB", {60'd0, srcB}, 64'h4);
    check("push_dstE", {60'd0, dstE}, 64'h4);
    check("push_dstM", {60'd0, dstM}, 64'hF);
    check("push_valA", valA, 64'd0);
    check("push_valB", valB, 64'd2048);
    check("push_icode", {60'd0, out_icode}, 64'hA);
    check("push_valC", out_valC, 64'h77);

    // writeback regs[2]=0x55 with no decode; outputs hold
    wb_dstE = 4'h2;
    wb_valE = 64'h55;
    tick();
    idle();
    check("hold_valid", {63'd0, out_valid}, 64'd0);
    check("hold_srcA", {60'd0, srcA}, 64'h3);
    check("hold_valB", valB, 64'd2048);

    // OPq %rdx,%rdx
    decode(4'h6, 4'h2, 4'h2, 64'h0);
    tick();
    idle();
    check("op_valA", valA, 64'h55);
    check("op_valB", valB, 64'h55);
    check("op_dstE", {60'd0, dstE}, 64'h2);

    // E and M both to %rsp: M wins
    wb_dstE = 4'h4;
    wb_valE = 64'd10;
    wb_dstM = 4'h4;
    wb_valM = 64'd20;
    tick();
    idle();
    decode(4'h9, 4'hF, 4'hF, 64'h0);
    tick();
    idle();
    check("ret_valA", valA, 64'd20);
    check("ret_valB", valB, 64'd20);
    check("ret_dstM", {60'd0, dstM}, 64'hF);

    // call: valA = valP
    decode(4'h8, 4'hF, 4'hF, 64'h109);
    tick();
    idle();
    check("call_valA", valA, 64'h109);
    check("call_srcA", {60'd0, srcA}, 64'hF);
    check("call_srcB", {60'd0, srcB}, 64'h4);
    check("call_dstE", {60'd0, dstE}, 64'h4);

    // popq %rsp: dstE and dstM both 4
    decode(4'hB, 4'h4, 4'hF, 64'h0);
    tick();
    idle();
    check("pop_dstM", {60'd0, dstM}, 64'h4);
    check("pop_srcA", {60'd0, srcA}, 64'h4);

    // regs[1]=3, then mrmovq reading rB=1 while M writes 7 to regs[1]
    wb_dstE = 4'h1;
    wb_valE = 64'd3;
    tick();
    idle();
    decode(4'h5, 4'h0, 4'h1, 64'h0);
    wb_dstM = 4'h1;
    wb_valM = 64'd7;
    tick();
    idle();
`ifdef DECODE_BYPASS_EN
    exp_bypass = 64'd7;
`else
    exp_bypass = 64'd3;
`endif
    check("mr_valB", valB, exp_bypass);
    check("mr_srcB", {60'd0, srcB}, 64'h1);
    check("mr_dstM", {60'd0, dstM}, 64'h0);

    // rrmovq reads regs[1] after the write landed
    decode(4'h2, 4'h1, 4'h3, 64'h0);
    tick();
    idle();
    check("rr_valA", valA, 64'd7);
    check("rr_dstE", {60'd0, dstE}, 64'h3);

    // address fault takes priority over halt
    decode(4'h0, 4'h1, 4'h2, 64'h0);
    imem_error = 1'b1;
    hlt        = 1'b1;
    tick();
    idle();
    check("adr_valid", {63'd0, out_valid}, 64'd1);
    check("adr_stat", {62'd0, stat}, 64'h2);
    check("adr_srcA", {60'd0, srcA}, 64'hF);
    check("adr_valA", valA, 64'd0);

    // ignored while faulted
    decode(4'h1, 4'hF, 4'hF, 64'h0);
    tick();
    idle();
    check("flt_valid", {63'd0, out_valid}, 64'd0);
    check("flt_stat", {62'd0, stat}, 64'h2);

    // reset overrides a simultaneous writeback to %rsp
    rst     = 1'b1;
    wb_dstE = 4'h4;
    wb_valE = 64'd77;
    decode(4'hA, 4'h3, 4'hF, 64'h0);
    tick();
    rst = 1'b0;
    idle();
    check("rst2_stat", {62'd0, stat}, 64'd0);
    check("rst2_valid", {63'd0, out_valid}, 64'd0);
    decode(4'hA, 4'h3, 4'hF, 64'h0);
    tick();
    idle();
    check("rst2_valB", valB, 64'd2048);
    check("rst2_valA", valA, 64'd0);

    // halt
    decode(4'h0, 4'hF, 4'hF, 64'h0);
    hlt = 1'b1;
    tick();
    idle();
    check("hlt_stat", {62'd0, stat}, 64'h1);
    check("hlt_valid", {63'd0, out_valid}, 64'd1);
    decode(4'h1, 4'hF, 4'hF, 64'h0);
    tick();
    idle();
    check("hlt_frozen", {63'd0, out_valid}, 64'd0);

    // illegal instruction beats halt
    do_reset();
    decode(4'hE, 4'hF, 4'hF, 64'h0);
    instr_validity = 1'b0;
    hlt            = 1'b1;
    tick();
    idle();
    check("ins_stat", {62'd0, stat}, 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
